// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the shift-register sequencer.
// State and direction values are fixed for software visibility.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_seq_ctrl_tick_prescaler.sv
// Single-clock tick enable: pulses once every div_val+1 enabled cycles.
// Counter never passes div_val, so the compare cannot overflow.
module tick_prescaler #(
  parameter int DIV_W = 32
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = en && (cnt_q == div_val);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Load-then-shift sequencer with start/busy/done handshake.
// Define SHIFT_ROTATE_EN to add the rot input for circular rotate.
import shift_ctrl_pkg::*;

module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 32,
  parameter int CNT_W = 4
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_data,
  input  logic [DIV_W-1:0] div_val,
  input  logic [CNT_W-1:0] shift_cnt,
  input  logic             ser_in,
`ifdef SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             dir_q;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] rem_q;
  logic             busy_q;
  logic             done_q;
  logic             fill;

  assign ser_out = (dir_q == DIR_RIGHT) ? q_q[0] : q_q[WIDTH-1];

`ifdef SHIFT_ROTATE_EN
  logic rot_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      rot_q <= rot;
    end
  end

  // Rotating feeds the departing bit back in at the other end.
  assign fill = rot_q ? ser_out : ser_in;
`else
  assign fill = ser_in;
`endif

  assign q_d = (dir_q == DIR_RIGHT) ? {fill, q_q[WIDTH-1:1]}
                                    : {q_q[WIDTH-2:0], fill};

  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_presc (
    .clkin   (clkin),
    .rst_n   (rst_n),
    .en      (state_q == SHIFT),
    .clr     (state_q == LOAD),
    .div_val (div_q),
    .tick    (tick)
  );

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      dir_q   <= DIR_LEFT;
      div_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            q_q     <= load_data;
            dir_q   <= dir;
            div_q   <= div_val;
            rem_q   <= shift_cnt;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (rem_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // Abort takes priority over a coincident tick.
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (tick) begin
            q_q   <= q_d;
            rem_q <= rem_q - ONE;
            if (rem_q == ONE) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign q    = q_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: stimulus pushes expected
// tick/done events, a monitor pops them as the DUT presents them.
module tb_shift_seq_ctrl;

  logic        clkin = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        dir = 1'b0;
  logic [7:0]  load_data = '0;
  logic [31:0] div_val = '0;
  logic [3:0]  shift_cnt = '0;
  logic        ser_in = 1'b0;
  logic        rot = 1'b0;
  logic [7:0]  q;
  logic        ser_out;
  logic        tick;
  logic        busy;
  logic        done;

  shift_seq_ctrl #(
    .WIDTH (8),
    .DIV_W (32),
    .CNT_W (4)
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .dir       (dir),
    .load_data (load_data),
    .div_val   (div_val),
    .shift_cnt (shift_cnt),
    .ser_in    (ser_in),
`ifdef SHIFT_ROTATE_EN
    .rot       (rot),
`endif
    .q         (q),
    .ser_out   (ser_out),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    bit         is_done;
    logic [7:0] qv;
    logic       so;
    int         off;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   base = 0;

  always @(posedge clkin) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function automatic void push(bit d, logic [7:0] qv, logic so, int off);
    exp_t e;
    e.is_done = d;
    e.qv = qv;
    e.so = so;
    e.off = off;
    sb.push_back(e);
  endfunction

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clkin);
      if (rst_n && (tick || done)) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", {30'd0, done, tick}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("event_kind", {31'd0, done}, {31'd0, e.is_done});
          chk("event_q", {24'd0, q}, {24'd0, e.qv});
          chk("event_cycle", cyc - base, e.off);
          if (e.is_done) chk("busy_at_done", {31'd0, busy}, 32'd0);
          else chk("ser_out_at_tick", {31'd0, ser_out}, {31'd0, e.so});
        end
      end
    end
  end

  task automatic start_seq(input logic [7:0] ld, input logic d,
                           input int dv, input int cnt,
                           input logic si, input logic r);
    load_data = ld;
    dir = d;
    div_val = dv;
    shift_cnt = cnt[3:0];
    ser_in = si;
    rot = r;
    start = 1'b1;
    base = cyc;
    @(negedge clkin);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || done) && n < 400) begin
      @(negedge clkin);
      n++;
    end
    if (n >= 400) chk({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_off(input int off);
    int n = 0;
    while ((cyc - base) < off && n < 400) begin
      @(negedge clkin);
      n++;
    end
    if (n >= 400) chk("wait_off_timeout", 32'd1, 32'd0);
  endtask

  task automatic t_right();
    push(0, 8'h01, 1'b1, 2);
    push(0, 8'h80, 1'b0, 3);
    push(0, 8'hC0, 1'b0, 4);
    push(1, 8'hE0, 1'b0, 5);
    start_seq(8'h01, 1'b1, 0, 3, 1'b1, 1'b0);
    wait_idle("right");
  endtask

  initial begin
    repeat (3) @(negedge clkin);
    chk("rst_q", {24'd0, q}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    rst_n = 1'b1;
    @(negedge clkin);

    // Left shift, div 3, four shifts
    push(0, 8'hA5, 1'b1, 5);
    push(0, 8'h4A, 1'b0, 9);
    push(0, 8'h94, 1'b1, 13);
    push(0, 8'h28, 1'b0, 17);
    push(1, 8'h50, 1'b0, 18);
    start_seq(8'hA5, 1'b0, 3, 4, 1'b0, 1'b0);
    wait_idle("left");

    t_right();

    // Abort coinciding with the third tick
    push(0, 8'hFF, 1'b1, 11);
    push(0, 8'hFE, 1'b1, 21);
    push(0, 8'hFC, 1'b1, 31);
    start_seq(8'hFF, 1'b0, 9, 8, 1'b0, 1'b0);
    wait_off(31);
    abort = 1'b1;
    @(negedge clkin);
    abort = 1'b0;
    chk("abort_q", {24'd0, q}, 32'h0000_00FC);
    chk("abort_busy", {31'd0, busy}, 32'd0);

    // Zero count, started right after abort
    push(1, 8'h3C, 1'b0, 2);
    start_seq(8'h3C, 1'b0, 5, 0, 1'b0, 1'b0);
    wait_idle("zero");
    chk("zero_q", {24'd0, q}, 32'h0000_003C);

    // Start ignored while busy, then async reset mid-SHIFT
    push(0, 8'h0F, 1'b0, 3);
    push(0, 8'h1F, 1'b0, 5);
    start_seq(8'h0F, 1'b0, 1, 5, 1'b1, 1'b0);
    @(negedge clkin);
    load_data = 8'h00;
    start = 1'b1;
    @(negedge clkin);
    start = 1'b0;
    wait_off(6);
    chk("pre_reset_q", {24'd0, q}, 32'h0000_003F);
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", {24'd0, q}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_tick", {31'd0, tick}, 32'd0);
    repeat (2) @(negedge clkin);
    rst_n = 1'b1;
    @(negedge clkin);
    t_right();

`ifdef SHIFT_ROTATE_EN
    push(0, 8'h81, 1'b1, 3);
    push(0, 8'hC0, 1'b0, 5);
    push(0, 8'h60, 1'b0, 7);
    push(0, 8'h30, 1'b0, 9);
    push(0, 8'h18, 1'b0, 11);
    push(0, 8'h0C, 1'b0, 13);
    push(0, 8'h06, 1'b0, 15);
    push(0, 8'h03, 1'b1, 17);
    push(1, 8'h81, 1'b1, 18);
    start_seq(8'h81, 1'b1, 1, 8, 1'b0, 1'b1);
    wait_idle("rotate");
`endif

    repeat (5) @(negedge clkin);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
